// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers N_ELEM exp words, sums them, then emits each element divided
// by the sum as an unsigned Q0.Q_W probability through a serial restoring divider.
module softmax_normalizer #(
    parameter int unsigned N_ELEM = 8,
    parameter int unsigned POS_W  = 5,
    parameter int unsigned MAN_W  = 16,
    parameter int unsigned Q_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [POS_W+MAN_W-1:0] in_exp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Q_W-1:0]         out_prob,
    output logic                   out_last,
    output logic                   err_zero,
    output logic                   busy
);
    localparam int unsigned IN_W   = POS_W + MAN_W;
    localparam int unsigned FX_W   = MAN_W + (1 << POS_W) - 1;
    localparam int unsigned IDX_W  = $clog2(N_ELEM);
    localparam int unsigned ACC_W  = FX_W + IDX_W;
    localparam int unsigned ITER_W = $clog2(Q_W + 2);

    typedef enum logic [1:0] {StCollect, StDiv, StOutput} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ITER_W-1:0] iter_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  rem_q;
    logic [ACC_W-1:0]  rem_nx;
    logic [ACC_W:0]    rem_sh;
    logic [Q_W:0]      low_q;
    logic [Q_W-1:0]    quo_q;
    logic [Q_W:0]      quo_fin;
    logic              q_bit;
    logic [FX_W-1:0]   f_in;
    logic [FX_W-1:0]   f_idx;
    logic [IN_W-1:0]   buf_q [N_ELEM];

    function automatic logic [FX_W-1:0] decode(input logic [IN_W-1:0] w);
        return FX_W'(w[MAN_W-1:0]) << w[IN_W-1:MAN_W];
    endfunction

    always_comb begin
        f_in    = decode(in_exp);
        f_idx   = decode(buf_q[idx_q]);
        rem_sh  = {rem_q, low_q[Q_W]};
        q_bit   = rem_sh >= {1'b0, acc_q};
        rem_nx  = q_bit ? ACC_W'(rem_sh - {1'b0, acc_q}) : rem_sh[ACC_W-1:0];
        quo_fin = {quo_q, q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == StCollect && in_valid && in_ready) begin
            buf_q[count_q] <= in_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StCollect;
            count_q   <= '0;
            idx_q     <= '0;
            iter_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            low_q     <= '0;
            quo_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prob  <= '0;
            out_last  <= 1'b0;
            err_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (in_valid && in_ready) begin
                        acc_q   <= acc_q + ACC_W'(f_in);
                        count_q <= count_q + 1'b1;
                        if (count_q == IDX_W'(N_ELEM - 1)) begin
                            state_q  <= StDiv;
                            idx_q    <= '0;
                            iter_q   <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                StDiv: begin
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == '0) begin
                        // F <= acc, so the dividend bits above the low Q_W+1 are already
                        // below the divisor; preload them and resolve only Q_W+1 bits.
                        rem_q <= ACC_W'(f_idx[FX_W-1:1]);
                        low_q <= {f_idx[0], Q_W'(0)};
                        quo_q <= '0;
                    end else begin
                        rem_q <= rem_nx;
                        low_q <= low_q << 1;
                        quo_q <= quo_fin[Q_W-1:0];
                        if (iter_q == ITER_W'(Q_W + 1)) begin
                            state_q   <= StOutput;
                            out_valid <= 1'b1;
                            out_last  <= (idx_q == IDX_W'(N_ELEM - 1));
                            err_zero  <= (acc_q == '0);
                            if (acc_q == '0) begin
                                out_prob <= '0;
                            end else if (quo_fin[Q_W]) begin
                                out_prob <= '1;
                            end else begin
                                out_prob <= quo_fin[Q_W-1:0];
                            end
                        end
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx_q == IDX_W'(N_ELEM - 1)) begin
                            state_q  <= StCollect;
                            acc_q    <= '0;
                            count_q  <= '0;
                            err_zero <= 1'b0;
                            out_last <= 1'b0;
                            out_prob <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            iter_q  <= '0;
                            state_q <= StDiv;
                        end
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_normalizer.sv
// Bench for softmax_normalizer: directed and random vectors checked against an arithmetic
// model of p_i = floor(e_i * 2^16 / sum(e)) with saturation and zero-sum flagging.
module tb_softmax_normalizer;
    localparam int N = 8;

    typedef logic [20:0] vec_t [N];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prob;
    logic        out_last;
    logic        err_zero;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    softmax_normalizer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_exp   (in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prob (out_prob),
        .out_last (out_last),
        .err_zero (err_zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Real value of an exp word scaled by 2^32: mantissa times 2^position.
    function automatic longint unsigned fx(input logic [20:0] w);
        return 64'(w[15:0]) * (64'd1 << w[20:16]);
    endfunction

    task automatic check_idle(input string name);
        check({name, " in_ready"}, in_ready, 1);
        check({name, " out_valid"}, out_valid, 0);
        check({name, " busy"}, busy, 0);
        check({name, " out_prob"}, out_prob, 0);
        check({name, " out_last"}, out_last, 0);
        check({name, " err_zero"}, err_zero, 0);
    endtask

    task automatic run_vector(input string name, input vec_t v, input bit gaps,
                              input int stall_idx, input int reset_idx);
        longint unsigned acc = 0;
        longint unsigned q;
        longint unsigned osum = 0;
        bit sat = 0;
        int cnt;
        for (int i = 0; i < N; i++) acc += fx(v[i]);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 0;
                    in_exp   = 21'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1;
            in_exp   = v[i];
            if (i == 0) check({name, " in_ready collect"}, in_ready, 1);
            @(negedge clk);
        end
        in_valid = 0;
        for (int i = 0; i < N; i++) begin
            cnt = 0;
            while (!out_valid && cnt < 40) begin
                if (cnt == 2) begin
                    check($sformatf("%s busy div[%0d]", name, i), busy, 1);
                    check($sformatf("%s in_ready div[%0d]", name, i), in_ready, 0);
                end
                in_valid = 1;
                in_exp   = 21'($urandom);
                if (i == reset_idx && cnt == 5) begin
                    rst_n = 0;
                    @(negedge clk);
                    rst_n    = 1;
                    in_valid = 0;
                    check_idle({name, " after reset"});
                    return;
                end
                @(negedge clk);
                cnt++;
            end
            in_valid = 0;
            check($sformatf("%s latency[%0d]", name, i), cnt, 18);
            q = (acc == 0) ? 0 : (fx(v[i]) << 16) / acc;
            if (q > 65535) begin
                q   = 65535;
                sat = 1;
            end
            check($sformatf("%s prob[%0d]", name, i), out_prob, q);
            check($sformatf("%s last[%0d]", name, i), out_last, (i == N - 1));
            check($sformatf("%s err_zero[%0d]", name, i), err_zero, (acc == 0));
            if (i == stall_idx) begin
                out_ready = 0;
                repeat (10) begin
                    @(negedge clk);
                    check($sformatf("%s stall valid[%0d]", name, i), out_valid, 1);
                    check($sformatf("%s stall prob[%0d]", name, i), out_prob, q);
                    check($sformatf("%s stall last[%0d]", name, i), out_last, (i == N - 1));
                end
            end
            osum += 64'(out_prob);
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
            check($sformatf("%s valid drop[%0d]", name, i), out_valid, 0);
        end
        check({name, " back in collect"}, in_ready, 1);
        check({name, " busy clear"}, busy, 0);
        check({name, " err_zero clear"}, err_zero, 0);
        if (!sat && acc != 0) begin
            check({name, " sum range"}, (osum >= 65536 - N && osum <= 65536), 1);
        end
    endtask

    initial begin
        vec_t v;
        rst_n     = 0;
        in_valid  = 0;
        in_exp    = '0;
        out_ready = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < N; i++) v[i] = {5'd16, 16'h8000};
        run_vector("uniform", v, 0, -1, -1);

        for (int i = 0; i < N; i++) v[i] = {5'($urandom_range(0, 31)), 16'h0000};
        v[3] = {5'd16, 16'h8000};
        run_vector("onehot", v, 0, -1, -1);

        for (int i = 0; i < N; i++) v[i] = {5'd31, 16'hFFFF};
        run_vector("maxrange", v, 0, -1, -1);

        for (int i = 0; i < N; i++) v[i] = {5'd0, 16'h0001};
        v[0] = {5'd31, 16'hFFFF};
        run_vector("mixed", v, 0, -1, -1);

        for (int i = 0; i < N; i++) v[i] = {5'($urandom_range(0, 31)), 16'h0000};
        run_vector("zerosum", v, 0, -1, -1);

        for (int i = 0; i < N; i++) v[i] = {5'($urandom_range(10, 14)), 16'($urandom)};
        run_vector("stall_gaps", v, 1, 2, -1);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) v[i] = {5'($urandom_range(0, 31)), 16'($urandom)};
            run_vector($sformatf("random%0d", t), v, t[0], -1, -1);
        end

        for (int i = 0; i < N; i++) v[i] = {5'd20, 16'($urandom)};
        run_vector("reset_mid", v, 0, -1, 4);

        for (int i = 0; i < N; i++) v[i] = {5'($urandom_range(4, 8)), 16'($urandom)};
        run_vector("post_reset", v, 0, -1, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
